mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the CPU's single memory port between two requesters: instruction fetch (port 0, driven by the control unit's fetch sequence) and data load/store (port 1, driven by the MAR/MDR path). It owns `mem_rd`/`mem_wr` toward memory, latches the address and write data of the granted request, and waits on a variable-latency `mem_ready`. It returns a one-cycle `done` pulse with registered read data. Ties are broken round-robin, so neither requester starves.

## Interface
- `ADDR_W`, 16, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, maximum wait cycles in BUSY before abort (used only with the macro).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_i[1:0]`  in  2  request; bit 0 = fetch, bit 1 = data.
- `wr_i[1:0]`  in  2  per-requester access type; 1 = write, 0 = read.
- `addr0_i`, `addr1_i`  in  ADDR_W  per-requester address.
- `wdata0_i`, `wdata1_i`  in  DATA_W  per-requester write data.
- `done_o[1:0]`  out  2  one-cycle completion pulse per requester.
- `err_o[1:0]`  out  2  timeout abort flag; valid only together with `done_o`.
- `rdata_o`  out  DATA_W  read data; valid while any `done_o` bit is high.
- `mem_rd`, `mem_wr`  out  1  memory strobes.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completion; a single-cycle pulse.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:** samples `req_i`.
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester not in `last_gnt`.
  - On grant: latch `gnt`, address, write data and `wr`; set `last_gnt` to the granted id; go to BUSY.
- **BUSY:** `mem_rd = !wr_latched`, `mem_wr = wr_latched`; `mem_addr`/`mem_wdata` come from the latches.
  - On `mem_ready`: capture `mem_rdata` (writes capture 0) and go to DONE.
- **DONE:** drives `done_o[gnt]` high for exactly one cycle, then goes to IDLE. `req_i` is ignored in DONE.
- **Requester rule:**
  - Hold `req`, `wr`, `addr` and `wdata` stable from assertion until `done` is seen.
  - Drop `req` in the cycle `done` is high, or keep it to issue a new access; a held `req` is re-sampled in the following IDLE cycle.
- **Outputs outside BUSY:** strobes are 0; `mem_addr`/`mem_wdata` hold their last latched value.
- **Reset values:** state IDLE, `last_gnt` = 1 (so fetch wins the first tie), all latches 0, every output 0.
- **Reset mid-access:** strobes drop immediately (asynchronous); no `done` is issued; the requester must re-request.
- **Same-requester back-to-back:** each access is fully sequenced; nothing is pipelined.

## Timing
- Request sampled at edge k: BUSY (strobe high) from k+1.
- Zero-wait memory (`mem_ready` in first BUSY cycle): DONE at k+2, IDLE at k+3. Minimum 3 cycles per access.
- N wait cycles add N cycles to BUSY.
- `rdata_o` is registered: valid in the DONE cycle, held until the next capture.
- Strobes are registered-state decodes, so they are glitch-free.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:**
  - A counter clears on entry to BUSY and increments each BUSY cycle without `mem_ready`.
  - On reaching `TIMEOUT` the block goes to DONE with `err_o[gnt]` = 1 and `rdata_o` = 0.
  - `mem_ready` arriving in the same cycle as the limit wins: normal completion, no error.
- **Not defined:** no counter; BUSY waits indefinitely; `err_o` is tied to 0 (the port is always present).

## Structure
- **Shared package `mem_pkg`:** `mem_arb_state_e` (IDLE/BUSY/DONE) and `REQ_FETCH` = 0, `REQ_DATA` = 1.
- **Sub-module `wait_timer`:** the timeout counter (clear, enable, `expired`), instantiated only under `MEM_ARB_TIMEOUT_EN`.
- Arbitration, latches and the FSM stay in `mem_arbiter`.

## Test plan
- Fetch read, addr 0x0010, `mem_ready` in first BUSY cycle returning 0xDEADBEEF -> `mem_rd` at k+1, `done_o` = 01 and `rdata_o` = 0xDEADBEEF at k+2.
- Both request at once after reset (data is a write of 0x12345678 to 0x0200) -> fetch granted first; then data granted, `mem_wr` = 1, `mem_addr` = 0x0200, `mem_wdata` = 0x12345678, `done_o` = 10.
- Both requests held continuously for 6 accesses -> grants alternate 0,1,0,1,0,1.
- Data read with 3 wait cycles -> BUSY lasts 4 cycles; `done_o` = 10 at k+5.
- `rst` pulsed mid-BUSY -> `mem_rd` drops in the same cycle, no `done`; the next request completes normally.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT` = 4 and no `mem_ready` -> `done_o` = 01, `err_o` = 01, `rdata_o` = 0 after 4 BUSY cycles; with `mem_ready` on the 4th cycle -> `err_o` = 00.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory-port arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_arb_state_e;

  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_DATA  = 1;

endpackage

// File: rtl/wait_timer.sv
// BUSY-cycle counter for the arbiter's timeout abort; only used when MEM_ARB_TIMEOUT_EN is defined.
module wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires during the LIMIT-th waiting cycle so the abort lands after exactly LIMIT BUSY cycles.
  assign expired = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single memory port (fetch = port 0, data = port 1).
// Optional timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        wr_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        done_o,
  output logic [1:0]        err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  mem_arb_state_e    state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_now;
  logic              sel;
  logic              timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant_now),
    .en     ((state_q == BUSY) && !mem_ready),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    wr_d       = wr_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    grant_now  = 1'b0;
    sel        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          // On a tie the requester that was not served last wins.
          sel        = (req_i == 2'b11) ? ~last_gnt_q : req_i[REQ_DATA];
          grant_now  = 1'b1;
          gnt_d      = sel;
          last_gnt_d = sel;
          wr_d       = wr_i[sel];
          addr_d     = sel ? addr1_i : addr0_i;
          wdata_d    = sel ? wdata1_i : wdata0_i;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_d = wr_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mem_rd    = (state_q == BUSY) && !wr_q;
  assign mem_wr    = (state_q == BUSY) && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done_o    = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign err_o     = done_o & {2{err_q}};
  assign rdata_o   = rdata_q;

endmodule
